// File: rtl/uart_cmd_master_pkg.sv
// Shared definitions for the 4-byte UART command link: opcodes, frame size,
// FSM state encoding and the frame packing helper.
package uart_cmd_master_pkg;

  localparam int         CMD_FRAME_BYTES = 4;
  localparam logic       CMD_OP_READ     = 1'b0;
  localparam logic       CMD_OP_WRITE    = 1'b1;
  localparam logic [1:0] LAST_BYTE_IDX   = 2'(CMD_FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_GAP       = 3'd3,
    ST_WAIT_RSP  = 3'd4
  } state_t;

  // Frame layout, first byte in the top lane: {op, addr, wdata_hi, wdata_lo}.
  // Read frames carry zero in the data bytes.
  function automatic logic [31:0] pack_frame(input logic op,
                                             input logic [7:0] addr,
                                             input logic [15:0] wdata);
    pack_frame = {7'b0, op, addr, (op == CMD_OP_READ) ? 16'h0000 : wdata};
  endfunction

endpackage

// File: rtl/uart_cmd_master_if.sv
// Request, byte-transmitter, byte-receiver and response signals of the
// command master, bundled so the link can be passed around as one port.
interface uart_cmd_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        cmd_done;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_timeout;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, tx_done, rx_dv, rx_byte,
    output cmd_ready, tx_dv, tx_byte, cmd_done, rsp_valid, rsp_data, rsp_timeout, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, tx_done, rx_dv, rx_byte,
    input  cmd_ready, tx_dv, tx_byte, cmd_done, rsp_valid, rsp_data, rsp_timeout, busy
  );

endinterface

// File: rtl/uart_cmd_timeout.sv
// Clear/enable counter that flags expiry on its LIMIT-th enabled cycle and
// then saturates. Shared with the board-side command decoder.
module uart_cmd_timeout #(
  parameter int LIMIT = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // Count enabled cycles from zero, holding at the expiry value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/uart_cmd_master.sv
// Initiator end of the 4-byte UART command link: packs one request into a
// frame, feeds it byte-by-byte to a UART transmitter with an idle gap between
// bytes, and for reads waits for a single reply byte or a timeout.
module uart_cmd_master
  import uart_cmd_master_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input logic             clk,
  input logic             rst,
  uart_cmd_master_if.master bus
);

  localparam int            GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t        state;
  state_t        next_state;
  logic [31:0]   frame_sr;
  logic          op_q;
  logic [1:0]    byte_idx;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    rsp_data_q;
  logic          rsp_valid_q;
  logic          rsp_expired;
  logic          byte_sent;
  logic          last_byte;

  assign byte_sent = (state == ST_WAIT_DONE) && bus.tx_done;
  assign last_byte = (byte_idx == LAST_BYTE_IDX);

  uart_cmd_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_WAIT_RSP),
    .enable (state == ST_WAIT_RSP),
    .expired(rsp_expired)
  );

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Walk the frame: one strobe per byte, wait for the transmitter, gap, repeat.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (bus.cmd_valid) next_state = ST_SEND;
      ST_SEND:      next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.tx_done) begin
                      if (!last_byte)                next_state = ST_GAP;
                      else if (op_q == CMD_OP_WRITE) next_state = ST_IDLE;
                      else                           next_state = ST_WAIT_RSP;
                    end
      ST_GAP:       if (gap_cnt == GAP_LAST) next_state = ST_SEND;
      ST_WAIT_RSP:  if (bus.rx_dv || rsp_expired) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Decoded strobes; a reply arriving on the expiry cycle suppresses the timeout.
  always_comb begin
    bus.cmd_ready   = (state == ST_IDLE);
    bus.busy        = (state != ST_IDLE);
    bus.tx_dv       = (state == ST_SEND);
    bus.cmd_done    = byte_sent && last_byte && (op_q == CMD_OP_WRITE);
    bus.rsp_timeout = rsp_expired && !bus.rx_dv;
  end

  // Frame shift register, byte index, gap timer and reply capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_sr    <= '0;
      op_q        <= CMD_OP_READ;
      byte_idx    <= '0;
      gap_cnt     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if ((state == ST_IDLE) && bus.cmd_valid) begin
        frame_sr <= pack_frame(bus.cmd_write, bus.cmd_addr, bus.cmd_wdata);
        op_q     <= bus.cmd_write;
        byte_idx <= '0;
      end
      if (byte_sent) begin
        frame_sr <= {frame_sr[23:0], 8'h00};
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
      if (state == ST_WAIT_RSP) begin
        if (bus.rx_dv) begin
          rsp_data_q  <= bus.rx_byte;
          rsp_valid_q <= 1'b1;
        end else if (rsp_expired) begin
          rsp_data_q <= 8'h00;
        end
      end
    end
  end

  assign bus.tx_byte   = frame_sr[31:24];
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_valid = rsp_valid_q;

endmodule
